// File: rtl/mips_commit_checker_pkg.sv
// Shared types for the MIPS in-order commit checker: event kinds, FSM states
// and the expected-event queue entry.
package mips_chk_pkg;

    localparam int CHK_DATA_W = 32;
    localparam int CHK_ADDR_W = 32;

    typedef enum logic [1:0] {
        CHK_REG  = 2'd0,
        CHK_MEM  = 2'd1,
        CHK_PC   = 2'd2,
        CHK_RSVD = 2'd3
    } chk_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

    typedef struct packed {
        chk_kind_t               kind;
        logic [CHK_ADDR_W-1:0]   addr;
        logic [CHK_DATA_W-1:0]   data;
    } chk_entry_t;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mips_commit_checker_if.sv
// Bundle of expected-event push, control, observed commit ports and status
// outputs of the commit checker. master drives stimulus, slave is the checker.
interface mips_commit_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic              exp_valid;
    logic              exp_ready;
    logic [1:0]        exp_kind;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              start;
    logic              clear;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] pc_value;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [CNT_W-1:0]  chk_count;
    logic [7:0]        err_count;
    logic [IDX_W-1:0]  first_fail_idx;

    modport master (
        output exp_valid, exp_kind, exp_addr, exp_data, start, clear,
               rf_we, rf_waddr, rf_wdata, mem_we, mem_addr, mem_wdata, pc_value,
        input  exp_ready, done, pass, fail, timeout, chk_count, err_count, first_fail_idx
    );

    modport slave (
        input  exp_valid, exp_kind, exp_addr, exp_data, start, clear,
               rf_we, rf_waddr, rf_wdata, mem_we, mem_addr, mem_wdata, pc_value,
        output exp_ready, done, pass, fail, timeout, chk_count, err_count, first_fail_idx
    );

endinterface

// File: rtl/mips_commit_checker_fifo.sv
// chk_fifo: DEPTH-entry synchronous FIFO of expected events with a
// synchronous flush; pushes when full and pops when empty are ignored.
module chk_fifo
    import mips_chk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  chk_entry_t                 data_i,
    output chk_entry_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    chk_entry_t       mem_q [DEPTH];
    logic [IDX_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + IDX_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + IDX_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/mips_commit_checker.sv
// In-order commit checker: retires one preloaded expected event per observed
// commit. Define CHK_TIMEOUT_EN to enable the idle watchdog.
module mips_commit_checker
    import mips_chk_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int REG_AW       = 5,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FAIL = 0,
    parameter int TIMEOUT      = 64
) (
    input logic                  clk,
    input logic                  reset,
    mips_commit_checker_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    chk_state_t       state_q;
    logic [CNT_W-1:0] chkCount_q;
    logic [7:0]       errCount_q, errCount_d;
    logic [IDX_W-1:0] firstFailIdx_q;
    logic             done_q, pass_q, fail_q, timeout_q;

    chk_entry_t       pushEntry, head;
    logic             push, pop, full, empty, lastPop;
    logic [CNT_W-1:0] fifoCount;
    logic             obsReg, bothWe, evalHead, headOk, timeoutHit;

    assign pushEntry = '{kind: chk_kind_t'(bus.exp_kind),
                         addr: CHK_ADDR_W'(bus.exp_addr),
                         data: CHK_DATA_W'(bus.exp_data)};
    assign push       = (state_q == ST_IDLE) && bus.exp_valid && !full && !bus.clear;
    assign pop        = (state_q == ST_RUN) && evalHead && !bus.clear;
    assign lastPop    = (fifoCount == CNT_W'(1));
    assign errCount_d = satInc8(errCount_q);

    chk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bus.clear),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pushEntry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifoCount)
    );

    // PC heads are judged immediately; other heads wait for a real commit.
    always_comb begin
        obsReg   = bus.rf_we && (bus.rf_waddr != '0);
        bothWe   = bus.rf_we && bus.mem_we;
        evalHead = 1'b0;
        headOk   = 1'b0;
        if (!empty) begin
            case (head.kind)
                CHK_PC: begin
                    evalHead = 1'b1;
                    headOk   = (bus.pc_value == head.data[DATA_W-1:0]) && !bothWe;
                end
                CHK_REG: begin
                    evalHead = obsReg || bus.mem_we;
                    headOk   = obsReg && !bus.mem_we
                               && (bus.rf_waddr == head.addr[REG_AW-1:0])
                               && (bus.rf_wdata == head.data[DATA_W-1:0]);
                end
                CHK_MEM: begin
                    evalHead = obsReg || bus.mem_we;
                    headOk   = bus.mem_we && !bothWe
                               && (bus.mem_addr == head.addr[ADDR_W-1:0])
                               && (bus.mem_wdata == head.data[DATA_W-1:0]);
                end
                default: begin
                    evalHead = obsReg || bus.mem_we;
                    headOk   = 1'b0;
                end
            endcase
        end
    end

`ifdef CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idleCnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idleCnt_q <= '0;
        end else if (bus.clear || (state_q != ST_RUN) || pop) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_q + IDLE_W'(1);
        end
    end

    assign timeoutHit = (state_q == ST_RUN) && !pop && (idleCnt_q == IDLE_W'(TIMEOUT - 1));
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT > 0);
    assign timeoutHit       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            chkCount_q     <= '0;
            errCount_q     <= '0;
            firstFailIdx_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else if (bus.clear) begin
            state_q        <= ST_IDLE;
            chkCount_q     <= '0;
            errCount_q     <= '0;
            firstFailIdx_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (empty && !push) begin
                            state_q <= ST_PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        chkCount_q <= chkCount_q + CNT_W'(1);
                        if (!headOk) begin
                            errCount_q <= errCount_d;
                            if (errCount_q == 8'd0) firstFailIdx_q <= chkCount_q[IDX_W-1:0];
                        end
                        if (!headOk && (STOP_ON_FAIL != 0)) begin
                            state_q <= ST_FAIL;
                            done_q  <= 1'b1;
                            fail_q  <= 1'b1;
                        end else if (lastPop) begin
                            done_q <= 1'b1;
                            if (headOk && (errCount_q == 8'd0)) begin
                                state_q <= ST_PASS;
                                pass_q  <= 1'b1;
                            end else begin
                                state_q <= ST_FAIL;
                                fail_q  <= 1'b1;
                            end
                        end
                    end else if (timeoutHit) begin
                        state_q   <= ST_FAIL;
                        done_q    <= 1'b1;
                        fail_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.exp_ready      = (state_q == ST_IDLE) && !full;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.fail           = fail_q;
    assign bus.timeout        = timeout_q;
    assign bus.chk_count      = chkCount_q;
    assign bus.err_count      = errCount_q;
    assign bus.first_fail_idx = firstFailIdx_q;

endmodule

// File: tb/tb_mips_commit_checker.sv
// Self-checking bench for mips_commit_checker: queue-based reference model,
// per-cycle comparison, directed scenarios and randomized rounds.
`timescale 1ns/1ps
module tb_mips_commit_checker;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 32;
    localparam int REG_AW       = 5;
    localparam int DEPTH        = 16;
    localparam int STOP_ON_FAIL = 0;
    localparam int TIMEOUT      = 64;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mips_commit_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

    mips_commit_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
        .STOP_ON_FAIL(STOP_ON_FAIL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } mEnt_t;

    mEnt_t mq[$];
    int    mState, mChk, mErr, mFirst, mIdle;
    bit    mTimeout;
    int    checks = 0;
    int    errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mState   = M_IDLE;
        mChk     = 0;
        mErr     = 0;
        mFirst   = 0;
        mIdle    = 0;
        mTimeout = 0;
    endtask

    // One clock of the reference model, using the rules for each event kind.
    task automatic modelStep();
        bit    isReg, both, ev, ok;
        mEnt_t e;
        if (bus.clear) begin
            modelReset();
            return;
        end
        if (mState == M_IDLE) begin
            if (bus.exp_valid && mq.size() < DEPTH) begin
                e.kind = int'(bus.exp_kind);
                e.addr = bus.exp_addr;
                e.data = bus.exp_data;
                mq.push_back(e);
            end
            if (bus.start) mState = (mq.size() > 0) ? M_RUN : M_PASS;
        end else if (mState == M_RUN) begin
            isReg = bus.rf_we && (bus.rf_waddr != 0);
            both  = bus.rf_we && bus.mem_we;
            e     = mq[0];
            ok    = 0;
            if (e.kind == 2) begin
                ev = 1;
                ok = (bus.pc_value == e.data) && !both;
            end else begin
                ev = isReg || bus.mem_we;
                if (e.kind == 0)
                    ok = isReg && !bus.mem_we && (bus.rf_waddr == e.addr[4:0]) && (bus.rf_wdata == e.data);
                else if (e.kind == 1)
                    ok = bus.mem_we && !bus.rf_we && (bus.mem_addr == e.addr) && (bus.mem_wdata == e.data);
            end
            if (ev) begin
                void'(mq.pop_front());
                mChk++;
                mIdle = 0;
                if (!ok) begin
                    if (mErr == 0) mFirst = (mChk - 1) % DEPTH;
                    if (mErr < 255) mErr++;
                end
                if (!ok && STOP_ON_FAIL != 0) mState = M_FAIL;
                else if (mq.size() == 0)      mState = (mErr == 0) ? M_PASS : M_FAIL;
            end else begin
`ifdef CHK_TIMEOUT_EN
                mIdle++;
                if (mIdle >= TIMEOUT) begin
                    mState   = M_FAIL;
                    mTimeout = 1;
                end
`endif
            end
        end
    endtask

    // Reference model advances on each clock edge and on asynchronous reset.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) modelReset();
            else        modelStep();
        end
    end

    // Every falling edge out of reset, all outputs are compared with the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("exp_ready", bus.exp_ready, (mState == M_IDLE && mq.size() < DEPTH));
                checkOutput("done", bus.done, (mState == M_PASS || mState == M_FAIL));
                checkOutput("pass", bus.pass, (mState == M_PASS));
                checkOutput("fail", bus.fail, (mState == M_FAIL));
                checkOutput("timeout", bus.timeout, mTimeout);
                checkOutput("chk_count", bus.chk_count, mChk);
                checkOutput("err_count", bus.err_count, mErr);
                checkOutput("first_fail_idx", bus.first_fail_idx, mFirst);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.exp_valid = 0; bus.exp_kind = 0; bus.exp_addr = 0; bus.exp_data = 0;
        bus.start = 0; bus.clear = 0;
        bus.rf_we = 0; bus.rf_waddr = 0; bus.rf_wdata = 0;
        bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        bus.pc_value = 0;
    endtask

    task automatic pushExpected(input int kind, input int addr, input int data);
        bus.exp_valid = 1;
        bus.exp_kind  = 2'(kind);
        bus.exp_addr  = 32'(addr);
        bus.exp_data  = 32'(data);
        tick();
        bus.exp_valid = 0;
    endtask

    task automatic applyStimulus(input bit rfWe, input int rfAddr, input int rfData,
                                 input bit memWe, input int memAddr, input int memData);
        bus.rf_we     = rfWe;
        bus.rf_waddr  = 5'(rfAddr);
        bus.rf_wdata  = 32'(rfData);
        bus.mem_we    = memWe;
        bus.mem_addr  = 32'(memAddr);
        bus.mem_wdata = 32'(memData);
        tick();
        bus.rf_we  = 0;
        bus.mem_we = 0;
    endtask

    task automatic startRun();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic clearPulse();
        bus.clear = 1;
        tick();
        bus.clear = 0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 300 && !bus.done; i++) tick();
        checkOutput(name, bus.done, 1);
    endtask

    task automatic runStandard(input int data3);
        pushExpected(0, 2, 5);
        pushExpected(0, 3, 2);
        pushExpected(0, 4, 10);
        pushExpected(1, 10, 20);
        pushExpected(2, 0, 32);
        bus.pc_value = 32;
        startRun();
        applyStimulus(1, 2, 5, 0, 0, 0);
        applyStimulus(1, 3, data3, 0, 0, 0);
        applyStimulus(1, 4, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 10, 20);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitDone("std.done");
    endtask

    task automatic randomRound(input int n);
        int r, kind;
        clearPulse();
        for (int i = 0; i < n; i++) begin
            r    = int'($urandom_range(0, 9));
            kind = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            pushExpected(kind, (kind == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)));
        end
        startRun();
        for (int c = 0; c < 300 && !bus.done; c++) begin
            bus.exp_valid = ($urandom_range(0, 3) == 0);
            bus.exp_kind  = 2'($urandom_range(0, 3));
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.pc_value  = 32'($urandom_range(0, 15));
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                if (mq[0].kind == 0)      applyStimulus(1, int'(mq[0].addr), int'(mq[0].data), 0, 0, 0);
                else if (mq[0].kind == 1) applyStimulus(0, 0, 0, 1, int'(mq[0].addr), int'(mq[0].data));
                else if (mq[0].kind == 2) begin
                    bus.pc_value = mq[0].data;
                    applyStimulus(0, 0, 0, 0, 0, 0);
                end else applyStimulus(1, 1, 0, 0, 0, 0);
            end else begin
                applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
        end
        bus.exp_valid = 0;
        bus.start     = 0;
        checkOutput("rand.done", bus.done, 1);
    endtask

    initial begin
        idleInputs();
        #2 reset = 1'b0;
        tick();
        tick();
        checkOutput("rst.exp_ready", bus.exp_ready, 1);
        checkOutput("rst.done", bus.done, 0);
        checkOutput("rst.chk_count", bus.chk_count, 0);
        checkOutput("rst.err_count", bus.err_count, 0);
        reset = 1'b1;
        tick();

        // Fully matching standard sequence.
        runStandard(2);
        checkOutput("t1.pass", bus.pass, 1);
        checkOutput("t1.chk_count", bus.chk_count, 5);
        checkOutput("t1.err_count", bus.err_count, 0);
        clearPulse();

        // $3 written with the wrong value.
        runStandard(7);
        checkOutput("t2.fail", bus.fail, 1);
        checkOutput("t2.chk_count", bus.chk_count, (STOP_ON_FAIL != 0) ? 2 : 5);
        checkOutput("t2.err_count", bus.err_count, 1);
        checkOutput("t2.first_fail_idx", bus.first_fail_idx, 1);

        // Clear from FAIL returns to an empty IDLE.
        clearPulse();
        checkOutput("clr.done", bus.done, 0);
        checkOutput("clr.err_count", bus.err_count, 0);
        checkOutput("clr.exp_ready", bus.exp_ready, 1);

        // Writes to $0 are invisible to the checker.
        pushExpected(0, 2, 5);
        pushExpected(1, 10, 20);
        startRun();
        applyStimulus(1, 0, 99, 0, 0, 0);
        applyStimulus(1, 2, 5, 0, 0, 0);
        applyStimulus(1, 0, 99, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 10, 20);
        waitDone("t3.done");
        checkOutput("t3.pass", bus.pass, 1);
        clearPulse();

        // Overfill: the DEPTH+1-th push is dropped.
        for (int i = 0; i < DEPTH; i++) pushExpected(0, i + 1, i + 100);
        checkOutput("t4.exp_ready", bus.exp_ready, 0);
        pushExpected(0, 17, 116);
        startRun();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, i + 1, i + 100, 0, 0, 0);
        waitDone("t4.done");
        checkOutput("t4.chk_count", bus.chk_count, DEPTH);
        checkOutput("t4.pass", bus.pass, 1);
        clearPulse();

`ifdef CHK_TIMEOUT_EN
        // Watchdog fires after TIMEOUT idle RUN cycles.
        pushExpected(0, 5, 1);
        startRun();
        repeat (TIMEOUT - 1) tick();
        checkOutput("t5.fail_early", bus.fail, 0);
        tick();
        checkOutput("t5.fail", bus.fail, 1);
        checkOutput("t5.timeout", bus.timeout, 1);
        checkOutput("t5.err_count", bus.err_count, 0);
        clearPulse();
`endif

        // Asynchronous reset in the middle of RUN.
        pushExpected(0, 1, 1);
        pushExpected(0, 2, 2);
        pushExpected(0, 3, 3);
        pushExpected(0, 4, 4);
        startRun();
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 2, 2, 0, 0, 0);
        checkOutput("t6.chk_before", bus.chk_count, 2);
        reset = 1'b0;
        #1;
        checkOutput("t6.chk_count", bus.chk_count, 0);
        checkOutput("t6.exp_ready", bus.exp_ready, 1);
        checkOutput("t6.done", bus.done, 0);
        #2 reset = 1'b1;
        tick();

        // Randomized rounds against the model.
        for (int k = 0; k < 20; k++) randomRound(int'($urandom_range(1, DEPTH)));

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_commit_checker.md
# mips_commit_checker

Synthesizable in-order commit checker for the MIPS single-cycle core: a bench or on-chip debug harness preloads a queue of expected architectural events (register write, memory store, PC value), then the block monitors the core's register-file and data-memory write ports and retires one expected event per observed commit. It reports pass/fail, error count, first failing index and an optional watchdog timeout. It generalises fixed-delay register/memory/PC spot checks into a parametrised, depth-configurable, order-checked scoreboard.

## Interface
- DATA_W, 32, data width of register/memory write data and PC
- ADDR_W, 32, memory address width (also used for expected-address field)
- REG_AW, 5, register-file address width
- DEPTH, 16, expected-event queue depth (power of two, ≥2)
- STOP_ON_FAIL, 0, 1: enter FAIL on first mismatch; 0: keep checking
- TIMEOUT, 64, idle-cycle limit for watchdog (used only with CHK_TIMEOUT_EN)

- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- exp_valid  in  1  expected-event push request
- exp_ready  out  1  queue accepts push
- exp_kind  in  2  0=REG, 1=MEM, 2=PC, 3=reserved
- exp_addr  in  ADDR_W  register index (low REG_AW bits) or memory address; ignored for PC
- exp_data  in  DATA_W  expected write data or PC value
- start  in  1  begin checking (IDLE only)
- clear  in  1  synchronous flush to IDLE
- rf_we, rf_waddr[REG_AW], rf_wdata[DATA_W]  in  observed register write
- mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]  in  observed store
- pc_value  in  DATA_W  current PC
- done  out  1  in PASS or FAIL
- pass  out  1  in PASS
- fail  out  1  in FAIL
- timeout  out  1  FAIL caused by watchdog
- chk_count  out  $clog2(DEPTH)+1  events retired
- err_count  out  8  mismatches, saturating at 255
- first_fail_idx  out  $clog2(DEPTH)  index of first mismatching event

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: exp_ready = !full; push on exp_valid&&exp_ready. start with queue non-empty → RUN; start with empty queue → PASS.
- RUN: exp_ready=0. Each cycle, a commit is observed if rf_we with rf_waddr≠0, or mem_we. rf_we to register 0 is ignored.
- Head REG: matches iff observed commit is register write, rf_waddr==exp_addr[REG_AW-1:0], rf_wdata==exp_data.
- Head MEM: matches iff store with mem_addr==exp_addr and mem_wdata==exp_data.
- Head PC: evaluated on the first RUN cycle it is head, regardless of commits; matches iff pc_value==exp_data; that cycle's commit is then not consumed (checked against the next head on the same cycle is NOT done; commits during a PC check are counted as mismatch only if rf_we&&mem_we).
- rf_we and mem_we both high same cycle: mismatch.
- Any evaluated head pops; chk_count++. Mismatch: err_count++ (saturate), first_fail_idx latched on first only; if STOP_ON_FAIL → FAIL.
- Queue empties in RUN → PASS if err_count==0 else FAIL.
- PASS/FAIL sticky until clear or reset. clear in any state: flush queue, zero counters, → IDLE.
- exp_kind 3 in queue: always mismatch.

## Timing
- Reset: state IDLE, queue empty, exp_ready=1, done/pass/fail/timeout=0, chk_count=err_count=first_fail_idx=0.
- All outputs registered; observation in cycle N updates counters/state visible at N+1.
- done rises one cycle after the final pop.
- Push and start same cycle: push accepted, then RUN uses updated queue next cycle.
- clear has priority over start and push; reset has priority over all.

## Configuration
- CHK_TIMEOUT_EN defined: idle counter reset on each pop, increments in RUN otherwise; reaching TIMEOUT → FAIL, timeout=1 (err_count unchanged).
- Undefined: no counter; timeout tied 0; RUN waits indefinitely.

## Structure
- Package mips_chk_pkg: chk_kind_t enum (REG/MEM/PC/RSVD), chk_state_t enum, expected-entry struct {kind, addr, data}.
- Sub-module chk_fifo: synchronous DEPTH-entry FIFO of entries with full/empty, push/pop, synchronous flush.

## Test plan
- Load REG($2,5), REG($3,2), REG($4,10), MEM(10,20), PC(32); drive matching commits → PASS, chk_count=5, err_count=0.
- Same queue, sub writes $3=7 → with STOP_ON_FAIL=0: FAIL after 5 pops, err_count=1, first_fail_idx=1; STOP_ON_FAIL=1: FAIL at pop 2.
- rf_we to $0 with data 99 interleaved → ignored, PASS.
- Push DEPTH+1 entries → exp_ready low after DEPTH; extra entry dropped; chk_count reaches DEPTH.
- CHK_TIMEOUT_EN, TIMEOUT=64, one REG entry, no commits → FAIL, timeout=1 at 64 cycles after start.
- Reset asserted mid-RUN after 2 pops → all outputs return to reset values immediately; clear in FAIL → IDLE, counters 0.
